// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with pipeline stall handshake.
// Optional build macro DIV_EARLY_OUT_EN: zero-divisor and signed-overflow cases finish straight from PREP.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             kill_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             is_signed;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      result_q  <= result_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    result_d  = result_q;

    is_signed = ~op_q[0];
    a_abs     = (is_signed & a_q[WIDTH-1]) ? -a_q : a_q;
    b_abs     = (is_signed & b_q[WIDTH-1]) ? -b_q : b_q;
    // Trial subtract; the top bit is the borrow that rejects the step
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};

    case (state_q)
      S_IDLE: begin
        if (start_i && !kill_i) begin
          op_d    = op_i;
          a_d     = src_a_i;
          b_d     = src_b_i;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        quo_d     = a_abs;
        dvs_d     = b_abs;
        rem_d     = '0;
        cnt_d     = '0;
        neg_quo_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_d = is_signed & a_q[WIDTH-1];
        b_zero_d  = (b_q == '0);
        state_d   = S_ITER;
`ifdef DIV_EARLY_OUT_EN
        if (b_q == '0) begin
          result_d = op_q[1] ? a_q : '1;
          state_d  = S_DONE;
        end else if (is_signed && (a_q == MIN_NEG) && (b_q == '1)) begin
          result_d = op_q[1] ? '0 : MIN_NEG;
          state_d  = S_DONE;
        end
`endif
      end
      S_ITER: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        // A zero divisor keeps the all-ones quotient regardless of signs
        if (op_q[1]) begin
          result_d = neg_rem_q ? -rem_q : rem_q;
        end else begin
          result_d = (neg_quo_q && !b_zero_q) ? -quo_q : quo_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (kill_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign result_o = result_q;
  assign done_o   = (state_q == S_DONE);
  assign busy_o   = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign stall_o  = reset_n_i & (busy_o | ((state_q == S_IDLE) & start_i & ~kill_i));

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed and randomized divides against an arithmetic reference.
module tb_div_sequencer;

  logic        clk_i;
  logic        reset_n_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        kill_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_exp = '0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .src_a_i   (src_a_i),
    .src_b_i   (src_b_i),
    .kill_i    (kill_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00:   if (b == 0) return 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
               else return 32'(sa / sb);
      2'b10:   if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
               else return 32'(sa % sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit special;
    special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    return special ? 1 : 34;
`else
    return special ? 34 : 34;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a negedge; returns at the negedge after DONE
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    logic [31:0] res;
    int lat_exp;
    int lat;
    int stalls;
    exp     = ref_model(op, a, b);
    lat_exp = exp_latency(op, a, b);
    lat     = -1;
    res     = 'x;
    op_i = op; src_a_i = a; src_b_i = b; start_i = 1'b1;
    #1;
    stalls = stall_o ? 1 : 0;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    op_i    = 2'($urandom);
    src_a_i = $urandom;
    src_b_i = $urandom;
    for (int k = 0; k < 60; k++) begin
      if (done_o) begin
        lat = k;
        res = result_o;
        check({tag, "_stall_in_done"}, 32'(stall_o), 32'd0);
        break;
      end
      if (stall_o) stalls++;
      @(negedge clk_i);
    end
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(lat_exp + 1));
    @(negedge clk_i);
    check({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
    last_exp = exp;
  endtask

  initial begin
    int ndone;
    int first_k;
    int second_k;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset_n_i = 1'b0; start_i = 1'b1; kill_i = 1'b0;
    op_i = 2'b01; src_a_i = 32'd1; src_b_i = 32'd1;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    reset_n_i = 1'b1;
    @(negedge clk_i);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0);
    run_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0);
    run_op("divu_m5_0", 2'b01, 32'hFFFF_FFFB, 32'd0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_ovf_pat", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);

    // Kill in the 10th ITER cycle
    op_i = 2'b01; src_a_i = 32'd1000; src_b_i = 32'd3; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    check("kill_busy", 32'(busy_o), 32'd0);
    check("kill_stall", 32'(stall_o), 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_o) ndone++;
      @(negedge clk_i);
    end
    check("kill_no_done", 32'(ndone), 32'd0);
    check("kill_result_held", result_o, last_exp);
    run_op("divu_9_3_after_kill", 2'b01, 32'd9, 32'd3);

    // start_i held across two instructions
    op_i = 2'b01; src_a_i = 32'd8; src_b_i = 32'd2; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    op_i = 2'b11; src_b_i = 32'd3;
    ndone = 0; first_k = -1; second_k = -1; r1 = 'x; r2 = 'x;
    for (int k = 0; k < 80; k++) begin
      if (done_o) begin
        ndone++;
        if (ndone == 1) begin
          first_k = k;
          r1 = result_o;
        end else if (ndone == 2) begin
          second_k = k;
          r2 = result_o;
          start_i = 1'b0;
        end
      end
      if (first_k >= 0 && k == first_k + 1) check("b2b_accept_stall", 32'(stall_o), 32'd1);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'd2);
    check("b2b_first_lat", 32'(first_k), 32'd34);
    check("b2b_second_lat", 32'(second_k), 32'd70);
    check("b2b_first_res", r1, ref_model(2'b01, 32'd8, 32'd2));
    check("b2b_second_res", r2, ref_model(2'b11, 32'd8, 32'd3));

    // Reset mid-operation
    op_i = 2'b00; src_a_i = 32'd77; src_b_i = 32'd5; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    reset_n_i = 1'b0;
    #1;
    check("midrst_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_o) ndone++;
      @(negedge clk_i);
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    check("midrst_result", result_o, 32'd0);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      if ($urandom_range(3) == 0) ra = 32'h8000_0000;
      case ($urandom_range(3))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
